// File: rtl/clk_tick_monitor.sv
// Slow-clock monitor: synchronizes an asynchronous divided clock, emits a tick per rising edge,
// measures period and high time, and tracks lock / sticky error status.
module clk_tick_monitor #(
  parameter int HALF_CYCLES = 250001,
  parameter int TOL         = 2,
  parameter int LOCK_COUNT  = 2,
  parameter int CNT_W       = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             err_clr,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic             err
);

  localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W:0] P_MIN   = (CNT_W+1)'(2*HALF_CYCLES - TOL);
  localparam logic [CNT_W:0] P_MAX   = (CNT_W+1)'(2*HALF_CYCLES + TOL);
  localparam logic [CNT_W:0] H_MIN   = (CNT_W+1)'(HALF_CYCLES - TOL);
  localparam logic [CNT_W:0] H_MAX   = (CNT_W+1)'(HALF_CYCLES + TOL);
  localparam logic [CNT_W:0] TIMEOUT = (CNT_W+1)'(2*HALF_CYCLES + TOL + 1);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t          state, state_next;
  logic            s1, s2, s3;
  logic            rise, fall;
  logic [CNT_W-1:0] cnt_p, cnt_h;
  logic [CNT_W:0]   h;
  logic [CNT_W:0]   p_meas;
  logic [GW-1:0]    good_cnt, good_next, good_inc;
  logic             good_rise, timeout;
  logic             fault, upd_period, clr_cnt;

  assign rise      = s2 & ~s3;
  assign fall      = ~s2 & s3;
  assign p_meas    = {1'b0, cnt_p} + (CNT_W+1)'(1);
  assign good_rise = (p_meas >= P_MIN) && (p_meas <= P_MAX) && (h >= H_MIN) && (h <= H_MAX);
  assign timeout   = ({1'b0, cnt_p} >= TIMEOUT);
  assign good_inc  = good_cnt + GW'(1);

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    fault      = 1'b0;
    upd_period = 1'b0;
    clr_cnt    = 1'b0;
    case (state)
      SEARCH: begin
        if (rise) begin
          state_next = MEASURE;
          good_next  = '0;
        end
      end
      MEASURE, LOCKED: begin
        if (rise) begin
          upd_period = 1'b1;
          if (!good_rise) begin
            fault      = 1'b1;
            state_next = MEASURE;
            good_next  = '0;
          end else if (state == MEASURE) begin
            good_next = good_inc;
            if (good_inc == GW'(LOCK_COUNT)) state_next = LOCKED;
          end
        end else if (timeout) begin
          fault      = 1'b1;
          state_next = SEARCH;
          good_next  = '0;
          clr_cnt    = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  // NOTE: every register below uses non-blocking assignment so all state updates on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      tick     <= 1'b0;
      period   <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
      cnt_p    <= '0;
      cnt_h    <= '0;
      h        <= '0;
      good_cnt <= '0;
      state    <= SEARCH;
    end else begin
      s1       <= slow_clk;
      s2       <= s1;
      s3       <= s2;
      tick     <= rise;
      state    <= state_next;
      good_cnt <= good_next;
      locked   <= (state_next == LOCKED);

      if (fault)        err <= 1'b1;
      else if (err_clr) err <= 1'b0;

      if (upd_period) period <= p_meas[CNT_W] ? '1 : p_meas[CNT_W-1:0];

      // A fall seen while searching has no matching rise, so its high time is meaningless.
      if (fall && state != SEARCH) h <= {1'b0, cnt_h} + (CNT_W+1)'(1);

      if (rise || clr_cnt) begin
        cnt_p <= '0;
        cnt_h <= '0;
      end else begin
        if (cnt_p != '1)        cnt_p <= cnt_p + CNT_W'(1);
        if (s2 && cnt_h != '1)  cnt_h <= cnt_h + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clk_tick_monitor.sv
// Randomized scoreboard bench for clk_tick_monitor: a segment-level model predicts the
// period / locked / err seen with every tick, and a monitor compares as ticks appear.
module tb_clk_tick_monitor;

  localparam int HC    = 5;
  localparam int TL    = 1;
  localparam int LK    = 2;
  localparam int W     = 8;
  localparam int S_SEARCH = 0;
  localparam int S_MEAS   = 1;
  localparam int S_LOCK   = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         slow_clk = 1'b0;
  logic         err_clr = 1'b0;
  logic         tick;
  logic [W-1:0] period;
  logic         locked;
  logic         err;

  clk_tick_monitor #(.HALF_CYCLES(HC), .TOL(TL), .LOCK_COUNT(LK), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .err_clr(err_clr),
    .tick(tick), .period(period), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    bit locked;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state, advanced once per slow_clk high/low segment.
  int m_state = S_SEARCH;
  int m_good  = 0;
  int m_period = 0;
  bit m_err   = 0;
  int prev_h  = 0;
  int prev_l  = 0;

  task automatic check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per observed tick.
  logic prev_tick = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_tick <= 1'b0;
    end else begin
      if (tick) begin
        check("tick_single_cycle", int'(prev_tick), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_tick", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("period_at_tick", int'(period), e.period);
          check("locked_at_tick", int'(locked), int'(e.locked));
          check("err_at_tick",    int'(err),    int'(e.err));
        end
      end
      prev_tick <= tick;
    end
  end

  task automatic model_reset();
    m_state  = S_SEARCH;
    m_good   = 0;
    m_period = 0;
    m_err    = 0;
  endtask

  // One slow_clk period: h cycles high then l cycles low.
  // clr_at: high-phase cycle index at which err_clr pulses (2 = same cycle as the rise, 4 = after it), -1 none.
  // rst_at: low-phase cycle index at which rst pulses for one clk, -1 none.
  task automatic run_seg(int h, int l, int clr_at, int rst_at);
    bit fault;
    int p;
    bit ok;
    bit did_rst;
    fault   = 0;
    did_rst = 0;
    if (m_state == S_SEARCH) begin
      m_state = S_MEAS;
      m_good  = 0;
    end else begin
      p  = prev_h + prev_l;
      ok = (p >= 2*HC-TL) && (p <= 2*HC+TL) && (prev_h >= HC-TL) && (prev_h <= HC+TL);
      m_period = p;
      if (ok) begin
        if (m_state == S_MEAS) begin
          m_good++;
          if (m_good == LK) m_state = S_LOCK;
        end
      end else begin
        fault   = 1;
        m_err   = 1;
        m_state = S_MEAS;
        m_good  = 0;
      end
    end
    if (clr_at == 2 && !fault) m_err = 0;
    exp_q.push_back('{m_period, (m_state == S_LOCK), m_err});
    if (clr_at == 4) m_err = 0;
    prev_h = h;
    prev_l = l;

    slow_clk = 1'b1;
    for (int c = 0; c < h; c++) begin
      err_clr = (c == clr_at);
      @(posedge clk); #1;
    end
    err_clr  = 1'b0;
    slow_clk = 1'b0;
    for (int c = 0; c < l; c++) begin
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_tick",   int'(tick),   0);
        check("rst_period", int'(period), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_err",    int'(err),    0);
        model_reset();
        did_rst = 1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end

    // A period long enough to let cnt_p reach the limit without a rise times out.
    if (!did_rst && m_state != S_SEARCH && h + l >= 2*HC+TL+3) begin
      m_err   = 1;
      m_state = S_SEARCH;
      m_good  = 0;
      if (h + l >= 2*HC+TL+6) begin
        check("timeout_err",    int'(err),    1);
        check("timeout_locked", int'(locked), 0);
        check("timeout_period", int'(period), m_period);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, l, ca, ra;
    rst = 1'b1;
    #12;
    check("reset_tick",   int'(tick),   0);
    check("reset_period", int'(period), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_err",    int'(err),    0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal lock-up, then a bad 7/5 period and relock.
    repeat (3) run_seg(5, 5, -1, -1);
    run_seg(7, 5, -1, -1);
    run_seg(5, 5, -1, -1);
    run_seg(5, 5, -1, -1);
    run_seg(5, 5, -1, -1);
    // Tolerance edges: 6/5 accepted, 6/6 rejected.
    run_seg(6, 5, -1, -1);
    run_seg(6, 6, -1, -1);
    run_seg(5, 5, 4, -1);
    run_seg(7, 5, -1, -1);
    run_seg(5, 5, 2, -1);
    run_seg(5, 5, 4, -1);
    // Relock, then hold low long enough to time out.
    repeat (3) run_seg(5, 5, -1, -1);
    run_seg(5, 20, -1, -1);
    run_seg(5, 5, -1, -1);
    run_seg(5, 5, -1, 2);
    run_seg(5, 5, -1, -1);
    run_seg(5, 5, -1, -1);
    run_seg(5, 5, -1, -1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        h = $urandom_range(3, 7);
        l = $urandom_range(14, 18);
      end else begin
        h = $urandom_range(3, 7);
        l = $urandom_range(3, 6);
      end
      ca = -1;
      if ($urandom_range(0, 4) == 0) ca = (h >= 5) ? 4 : 2;
      ra = ($urandom_range(0, 14) == 0) ? 1 : -1;
      run_seg(h, l, ca, ra);
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
